// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-scheduling sequencer: sizes and the KSA state encoding.
package rc4_pkg;

    localparam int S_SIZE    = 256;
    localparam int KEY_IDX_W = 4;
    localparam int DATA_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RD_I,
        CAP_I,
        RD_J,
        WR_I,
        WR_J,
        DONE
    } ksa_state_t;

endpackage

// File: rtl/rc4_ksa_ctrl.sv
// RC4 KSA sequencer: fills the S-box with the identity permutation, then runs the 256
// key-driven swaps, parking S[i] in the external location register across each swap.
module rc4_ksa_ctrl
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start_i,
    output logic [KEY_IDX_W-1:0] key_idx_o,
    input  logic [DATA_W-1:0]    key_byte_i,
    output logic [DATA_W-1:0]    mem_addr_o,
    output logic                 mem_re_o,
    input  logic [DATA_W-1:0]    mem_rdata_i,
    output logic                 mem_we_o,
    output logic [DATA_W-1:0]    mem_wdata_o,
    output logic                 store_loc_o,
    output logic [DATA_W-1:0]    loc_end_o,
    input  logic [DATA_W-1:0]    loc_safe_i,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic [DATA_W-1:0]    I_LAST   = DATA_W'(S_SIZE - 1);
    localparam logic [KEY_IDX_W-1:0] KEY_LAST = KEY_IDX_W'(KEY_BYTES - 1);

    ksa_state_t           state_q, state_d;
    logic [DATA_W-1:0]    i_q, i_d;
    logic [DATA_W-1:0]    j_q, j_d;
    logic [KEY_IDX_W-1:0] kidx_q, kidx_d;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            kidx_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            kidx_q  <= kidx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        kidx_d      = kidx_q;
        mem_addr_o  = '0;
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        store_loc_o = 1'b0;
        loc_end_o   = '0;
        done_o      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = INIT;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                end
            end
            INIT: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = i_q;
                mem_wdata_o = i_q;
                // i rolls over to 0 naturally, ready for the first swap iteration
                i_d         = i_q + 8'd1;
                if (i_q == I_LAST) begin
                    state_d = RD_I;
                end
            end
            RD_I: begin
                mem_re_o   = 1'b1;
                mem_addr_o = i_q;
                state_d    = CAP_I;
            end
            CAP_I: begin
                store_loc_o = 1'b1;
                loc_end_o   = mem_rdata_i;
                j_d         = j_q + mem_rdata_i + key_byte_i;
                state_d     = RD_J;
            end
            RD_J: begin
                mem_re_o   = 1'b1;
                mem_addr_o = j_q;
                state_d    = WR_I;
            end
            WR_I: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = i_q;
                mem_wdata_o = mem_rdata_i;
                state_d     = WR_J;
            end
            WR_J: begin
                // When i == j both writes carry the same byte, so no special case is needed
                mem_we_o    = 1'b1;
                mem_addr_o  = j_q;
                mem_wdata_o = loc_safe_i;
                if (i_q == I_LAST) begin
                    i_d     = '0;
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    kidx_d  = (kidx_q == KEY_LAST) ? '0 : kidx_q + 4'd1;
                    state_d = RD_I;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign key_idx_o = kidx_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_rc4_ksa_ctrl.sv
// Self-checking bench for rc4_ksa_ctrl: SRAM and location-register models around the DUT,
// results compared against a plain software KSA computed in the bench.
module tb_rc4_ksa_ctrl;

    localparam int KB = 3;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start_i = 1'b0;
    logic [3:0] key_idx_o;
    logic [7:0] key_byte_i;
    logic [7:0] mem_addr_o;
    logic       mem_re_o;
    logic [7:0] mem_rdata_i;
    logic       mem_we_o;
    logic [7:0] mem_wdata_o;
    logic       store_loc_o;
    logic [7:0] loc_end_o;
    logic [7:0] loc_safe_i;
    logic       busy_o;
    logic       done_o;

    always #5 clk = ~clk;

    rc4_ksa_ctrl #(.KEY_BYTES(KB)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start_i     (start_i),
        .key_idx_o   (key_idx_o),
        .key_byte_i  (key_byte_i),
        .mem_addr_o  (mem_addr_o),
        .mem_re_o    (mem_re_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .store_loc_o (store_loc_o),
        .loc_end_o   (loc_end_o),
        .loc_safe_i  (loc_safe_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    // Environment: key store, S-box SRAM with registered read, store-on-strobe location register
    logic [7:0] key_mem [16];
    logic [7:0] sram [256];
    logic [7:0] loc_q;

    always_comb key_byte_i = key_mem[key_idx_o];

    always @(posedge clk) begin
        if (mem_we_o)    sram[mem_addr_o] <= mem_wdata_o;
        if (mem_re_o)    mem_rdata_i      <= sram[mem_addr_o];
        if (store_loc_o) loc_q            <= loc_end_o;
    end
    assign loc_safe_i = loc_q;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference KSA
    logic [7:0] exp_s  [256];
    int         exp_j  [256];
    int         exp_wi [256];
    int         exp_wj [256];

    task automatic model();
        int j;
        logic [7:0] t;
        j = 0;
        for (int k = 0; k < 256; k++) exp_s[k] = 8'(k);
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(exp_s[i]) + int'(key_mem[i % KB])) % 256;
            exp_j[i]  = j;
            exp_wi[i] = int'(exp_s[j]);
            exp_wj[i] = int'(exp_s[i]);
            t = exp_s[i]; exp_s[i] = exp_s[j]; exp_s[j] = t;
        end
    endtask

    typedef struct { int cyc; int addr; int data; } ev_t;
    ev_t wlog[$];
    ev_t rlog[$];
    ev_t slog[$];
    int conflicts, zero_viol, kidx_bad, done_cyc, done_cnt, idle_cyc;

    function automatic int ev_get(input ev_t q[$], input int k, input int field);
        if (k >= q.size()) return -1;
        case (field)
            0:       return q[k].cyc;
            1:       return q[k].addr;
            default: return q[k].data;
        endcase
    endfunction

    task automatic run_ksa(input bit hold, input int stop_cyc);
        int cyc;
        wlog.delete(); rlog.delete(); slog.delete();
        conflicts = 0; zero_viol = 0; kidx_bad = 0;
        done_cyc = -1; done_cnt = 0; idle_cyc = -1;
        start_i = 1'b1;
        tick();
        cyc = 1;
        if (!hold) start_i = 1'b0;
        while (cyc <= 2000) begin
            if (mem_we_o)    wlog.push_back('{cyc, int'(mem_addr_o), int'(mem_wdata_o)});
            if (mem_re_o)    rlog.push_back('{cyc, int'(mem_addr_o), 0});
            if (store_loc_o) slog.push_back('{cyc, 0, int'(loc_end_o)});
            if (int'(mem_re_o) + int'(mem_we_o) + int'(store_loc_o) > 1) conflicts++;
            if (!mem_we_o && mem_wdata_o != 8'd0) zero_viol++;
            if (!mem_we_o && !mem_re_o && mem_addr_o != 8'd0) zero_viol++;
            if (!store_loc_o && loc_end_o != 8'd0) zero_viol++;
            if (int'(key_idx_o) >= KB) kidx_bad++;
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (!busy_o) begin
                idle_cyc = cyc;
                break;
            end
            if (cyc == stop_cyc) break;
            if (hold && cyc == 304) start_i = 1'b0;
            if (hold && cyc == 305) start_i = 1'b1;
            tick();
            cyc++;
        end
    endtask

    task automatic check_run(input string tag);
        int init_bad, swap_bad, store_bad, sbox_bad;
        init_bad = 0; swap_bad = 0; store_bad = 0; sbox_bad = 0;
        for (int k = 0; k < 256; k++)
            if (ev_get(wlog, k, 0) != k + 1 || ev_get(wlog, k, 1) != k || ev_get(wlog, k, 2) != k)
                init_bad++;
        for (int it = 0; it < 256; it++) begin
            if (ev_get(wlog, 256 + 2*it, 0) != 260 + 5*it || ev_get(wlog, 256 + 2*it, 1) != it ||
                ev_get(wlog, 256 + 2*it, 2) != exp_wi[it]) swap_bad++;
            if (ev_get(wlog, 257 + 2*it, 0) != 261 + 5*it || ev_get(wlog, 257 + 2*it, 1) != exp_j[it] ||
                ev_get(wlog, 257 + 2*it, 2) != exp_wj[it]) swap_bad++;
            if (ev_get(slog, it, 0) != 258 + 5*it || ev_get(slog, it, 2) != exp_wj[it]) store_bad++;
        end
        for (int k = 0; k < 256; k++) if (sram[k] !== exp_s[k]) sbox_bad++;
        check({tag, " done_cycle"}, done_cyc, 1537);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " idle_cycle"}, idle_cyc, 1538);
        check({tag, " write_count"}, wlog.size(), 768);
        check({tag, " first_rd_i_cycle"}, ev_get(rlog, 0, 0), 257);
        check({tag, " first_rd_i_addr"}, ev_get(rlog, 0, 1), 0);
        check({tag, " init_writes_bad"}, init_bad, 0);
        check({tag, " swap_writes_bad"}, swap_bad, 0);
        check({tag, " loc_stores_bad"}, store_bad, 0);
        check({tag, " strobe_conflicts"}, conflicts, 0);
        check({tag, " idle_outputs_nonzero"}, zero_viol, 0);
        check({tag, " key_idx_range"}, kidx_bad, 0);
        check({tag, " sbox_bytes_bad"}, sbox_bad, 0);
        $display("run %s: done at cycle %0d, %0d writes, S[0..3]=%02h %02h %02h %02h",
                 tag, done_cyc, wlog.size(), sram[0], sram[1], sram[2], sram[3]);
    endtask

    task automatic set_key(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
        for (int k = 0; k < 16; k++) key_mem[k] = 8'h00;
        key_mem[0] = k0; key_mem[1] = k1; key_mem[2] = k2;
        model();
    endtask

    initial begin
        set_key(8'h00, 8'h00, 8'h00);
        n_rst = 1'b0;
        tick(); tick(); tick();
        check("reset busy", busy_o, 0);
        check("reset done", done_o, 0);
        check("reset strobes", {mem_re_o, mem_we_o, store_loc_o}, 0);
        check("reset addr", mem_addr_o, 0);
        check("reset key_idx", key_idx_o, 0);
        n_rst = 1'b1;
        tick();

        // Zero key: identity init, i == j self swap on the first iteration
        run_ksa(1'b0, 0);
        check_run("zero_key");
        check("self_swap wr_i", {ev_get(wlog, 256, 1), ev_get(wlog, 256, 2)}, 0);
        check("self_swap wr_j", {ev_get(wlog, 257, 1), ev_get(wlog, 257, 2)}, 0);
        check("self_swap next_rd_i", ev_get(rlog, 2, 1), 1);
        check("self_swap next_rd_i_cycle", ev_get(rlog, 2, 0), 262);

        // key[0] = 1: first swap exchanges S[0] and S[1]
        set_key(8'h01, 8'h00, 8'h00);
        run_ksa(1'b0, 0);
        check_run("first_swap");
        check("first_swap cap_i", ev_get(slog, 0, 2), 0);
        check("first_swap rd_j_addr", ev_get(rlog, 1, 1), 1);
        check("first_swap wr_i", ev_get(wlog, 256, 2), 1);
        check("first_swap wr_j_addr", ev_get(wlog, 257, 1), 1);
        check("first_swap wr_j_data", ev_get(wlog, 257, 2), 0);

        set_key(8'h4B, 8'h65, 8'h79);
        run_ksa(1'b0, 0);
        check_run("key_Key");

        for (int r = 0; r < 2; r++) begin
            set_key(8'($urandom), 8'($urandom), 8'($urandom));
            run_ksa(1'b0, 0);
            check_run($sformatf("random%0d", r));
        end

        // Reset while in RD_J of iteration i=5
        set_key(8'($urandom), 8'($urandom), 8'($urandom));
        run_ksa(1'b0, 284);
        check("midrun rd_j re", mem_re_o, 1);
        check("midrun rd_j addr", mem_addr_o, exp_j[5]);
        n_rst = 1'b0;
        tick();
        check("midrun reset busy", busy_o, 0);
        check("midrun reset strobes", {mem_re_o, mem_we_o, store_loc_o, done_o}, 0);
        check("midrun reset addr", mem_addr_o, 0);
        n_rst = 1'b1;
        tick();
        check("midrun idle after release", busy_o, 0);
        run_ksa(1'b0, 0);
        check_run("after_reset");

        // start held high, re-pulsed in WR_I: one run, then re-accepted only from IDLE
        set_key(8'($urandom), 8'($urandom), 8'($urandom));
        run_ksa(1'b1, 0);
        check_run("start_held");
        tick();
        check("restart from idle busy", busy_o, 1);
        check("restart from idle init", {mem_we_o, mem_addr_o, mem_wdata_o}, {1'b1, 16'h0000});
        start_i = 1'b0;
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_ksa_ctrl.md
# rc4_ksa_ctrl

Sequencer for the RC4 key-scheduling algorithm (KSA) in the decryption datapath. Owns the 256-byte S-box SRAM port during scheduling: initialises S[k]=k, then performs the 256 index/swap iterations. Parks S[i] in the existing store-on-strobe location register across each swap, driving its strobe and data and reading back its held value. Sits between the top-level decrypt FSM (start/done) and the S-box SRAM plus location register.

## Interface
- KEY_BYTES, 8: key length in bytes; legal range 1..16.
- clk  in  1  system clock, all state updates on rising edge.
- n_rst  in  1  reset; **synchronous, active-low**: sampled only on rising clk; reset is synchronous and active-low.
- start_i  in  1  begin KSA; sampled only in IDLE.
- key_idx_o  out  4  key byte index = i mod KEY_BYTES.
- key_byte_i  in  8  key byte at key_idx_o, combinational from key store.
- mem_addr_o  out  8  S-box address.
- mem_re_o  out  1  S-box read enable; data valid on mem_rdata_i the next cycle.
- mem_rdata_i  in  8  S-box read data.
- mem_we_o  out  1  S-box write enable.
- mem_wdata_o  out  8  S-box write data.
- store_loc_o  out  1  location register load strobe.
- loc_end_o  out  8  data to location register.
- loc_safe_i  in  8  location register output.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, INIT, RD_I, CAP_I, RD_J, WR_I, WR_J, DONE.
- IDLE: all strobes 0. start_i=1 -> INIT; clear i, j, key index.
- INIT: we=1, addr=i, wdata=i; i++ each cycle; at i=255 wrap i to 0 -> RD_I.
- RD_I: re=1, addr=i.
- CAP_I: store_loc_o=1, loc_end_o=mem_rdata_i (=S[i]); j <= j + S[i] + key_byte_i (8-bit, mod 256) -> RD_J.
- RD_J: re=1, addr=j (updated j).
- WR_I: we=1, addr=i, wdata=mem_rdata_i (=S[j]).
- WR_J: we=1, addr=j, wdata=loc_safe_i (old S[i]). If i=255 -> DONE, else i++, key index++ (wrap at KEY_BYTES-1 to 0) -> RD_I.
- DONE: done_o=1 one cycle -> IDLE.
- i==j: both writes hit the same address with the same value; S unchanged. No special case.
- start_i outside IDLE ignored; no restart, no queuing.
- re and we never high together; at most one of re/we/store_loc_o per cycle.

## Timing
- Reset (n_rst=0 at edge): state IDLE, i=j=0, key index 0; all outputs 0 next cycle, regardless of state (mid-operation included). SRAM contents after aborted run are undefined; a new start fully reinitialises.
- Output values: all outputs registered-state decoded (Moore); mem_addr_o/mem_wdata_o/loc_end_o are 0 when their enable is low.
- Key index stays stable from RD_I through CAP_I; key_byte_i sampled at CAP_I edge.
- Latency: start sampled at edge 0 -> INIT cycles 1..256 -> swap cycles 257..1536 (5 per iteration) -> done_o high cycle 1537 -> busy_o low cycle 1538.

## Structure
- Shared package rc4_pkg: state enum type ksa_state_t, S_SIZE=256, KEY_IDX_W=4, DATA_W=8.
- Flat module, no sub-module; the location register remains a separate instance wired by the parent.

## Test plan
- Init: KEY_BYTES=1, key 0x00, start -> 256 writes addr k data k at cycles 1..256; first RD_I at cycle 257 addr 0.
- First swap: key[0]=0x01 -> CAP_I stores 0x00, j=0x01; WR_I writes addr 0 data 0x01, WR_J writes addr 1 data 0x00.
- Self swap: key all 0x00, i=0 -> j=0; S[0] stays 0x00; i increments normally.
- Full vector: KEY_BYTES=3, key 4B 65 79 ("Key") -> final 256-byte S-box equals software KSA model; done_o exactly at cycle 1537, one cycle wide.
- Reset mid-run: n_rst=0 during RD_J at i=5 -> next cycle busy_o=0, re/we/store_loc_o=0; new start re-runs INIT from addr 0.
- start_i held high for the whole run and re-pulsed during WR_I -> no restart; exactly one done_o; start accepted again only in IDLE.
